contador_ad_bcd_gen: RTL



---
 rtl/contador_pkg.sv | 41 ++++
 rtl/contador_ad_bcd_gen_bin2bcd.sv | 24 ++
 rtl/contador_ad_bcd_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/contador_pkg.sv
// Shared constants and BCD helpers for the RTC field adjust counters.
// Holds field IDs, per-field default ranges, autorepeat timing and BCD conversions.
package contador_pkg;

    localparam int FIELD_SEG = 1;
    localparam int FIELD_MIN = 2;
    localparam int FIELD_HOR = 3;
    localparam int FIELD_DAY = 6;
    localparam int FIELD_MES = 7;
    localparam int FIELD_ANO = 8;

    localparam int MIN_SEG = 0;
    localparam int MAX_SEG = 59;
    localparam int MIN_MIN = 0;
    localparam int MAX_MIN = 59;
    localparam int MIN_HOR = 0;
    localparam int MAX_HOR = 23;
    localparam int MIN_DAY = 1;
    localparam int MAX_DAY = 31;
    localparam int MIN_MES = 1;
    localparam int MAX_MES = 12;
    localparam int MIN_ANO = 0;
    localparam int MAX_ANO = 99;

    localparam int REPEAT_DELAY  = 16;
    localparam int REPEAT_PERIOD = 4;

    // Up to three digits; narrower fields are zero-extended by the caller.
    function automatic logic bcd_valid(input logic [11:0] b);
        return (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic [9:0] bcd_to_bin(input logic [11:0] b);
        return 10'(b[11:8]) * 10'd100 + 10'(b[7:4]) * 10'd10 + 10'(b[3:0]);
    endfunction

    function automatic logic [11:0] bin_to_bcd12(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/contador_ad_bcd_gen_bin2bcd.sv
// Combinational double-dabble: N-bit binary to DIGITS packed BCD nibbles.
module bin2bcd_dig #(
    parameter int N      = 7,
    parameter int DIGITS = 2
) (
    input  logic [N-1:0]          bin,
    output logic [4*DIGITS-1:0]   bcd
);

    logic [4*DIGITS-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (acc[4*d +: 4] >= 4'd5)
                    acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
            acc = {acc[4*DIGITS-2:0], bin[i]};
        end
        bcd = acc;
    end

endmodule

// File: rtl/contador_ad_bcd_gen.sv
// Up/down RTC field counter with BCD load, run-time limit clamping and carry/borrow.
// Optional hold-to-repeat stepping is enabled by defining CONTADOR_AUTOREPEAT_EN.
module contador_ad_bcd_gen
    import contador_pkg::*;
#(
    parameter int FIELD_ID = 6,
    parameter int N        = 7,
    parameter int DIGITS   = 2,
    parameter int MIN_VAL  = 1,
    parameter int MAX_VAL  = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            en_count,
    input  logic                  enUP,
    input  logic                  enDOWN,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_bcd,
    input  logic [N-1:0]          dyn_max,
    output logic [4*DIGITS-1:0]   data_bcd,
    output logic [N-1:0]          count_bin,
    output logic                  carry,
    output logic                  borrow,
    output logic                  load_err
);

    localparam logic [3:0]          FIELD_SEL = 4'(FIELD_ID);
    localparam logic [N-1:0]        MIN_N     = N'(MIN_VAL);
    localparam logic [N-1:0]        MAX_N     = N'(MAX_VAL);
    localparam logic [11:0]         RST_BCD12 = bin_to_bcd12(MIN_VAL);
    localparam logic [4*DIGITS-1:0] RST_BCD   = RST_BCD12[4*DIGITS-1:0];

    logic [N-1:0]        count_reg;
    logic [4*DIGITS-1:0] data_bcd_reg;
    logic                carry_reg, borrow_reg, load_err_reg;
    logic [N-1:0]        lim;
    logic [4*DIGITS-1:0] bcd_comb;
    logic                sel, up_req, dn_req, step_up, step_dn;
    logic [11:0]         load_ext;
    logic [9:0]          load_val;
    logic                load_ok;

    always_comb begin
        if (dyn_max > MAX_N)
            lim = MAX_N;
        else if (dyn_max < MIN_N)
            lim = MIN_N;
        else
            lim = dyn_max;
    end

    assign sel    = (en_count == FIELD_SEL);
    assign up_req = sel & enUP;
    assign dn_req = sel & enDOWN & ~enUP;

    // Range check is done wider than N so an oversized BCD value cannot alias into range.
    assign load_ext = 12'(load_bcd);
    assign load_val = bcd_to_bin(load_ext);
    assign load_ok  = bcd_valid(load_ext)
                      && (32'(load_val) >= 32'(MIN_VAL))
                      && (32'(load_val) <= 32'(lim));

`ifdef CONTADOR_AUTOREPEAT_EN
    localparam logic [4:0] HOLD_FIRE   = 5'(REPEAT_DELAY);
    localparam logic [4:0] HOLD_RELOAD = 5'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    logic [4:0] hold_reg;
    logic       active_reg, dir_up_reg;
    logic       req_active, same_run, fire;
    logic [4:0] eff_hold;

    // hold counts cycles the same request has already been held; it folds back after each
    // repeat so the repeat phase never needs a wide counter.
    assign req_active = up_req | dn_req;
    assign same_run   = active_reg && (dir_up_reg == up_req);
    assign eff_hold   = same_run ? hold_reg : 5'd0;
    assign fire       = (eff_hold == 5'd0) || (eff_hold == HOLD_FIRE);
    assign step_up    = up_req & fire;
    assign step_dn    = dn_req & fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg   <= '0;
            active_reg <= 1'b0;
            dir_up_reg <= 1'b0;
        end else if (load || !req_active) begin
            hold_reg   <= '0;
            active_reg <= 1'b0;
            dir_up_reg <= 1'b0;
        end else begin
            active_reg <= 1'b1;
            dir_up_reg <= up_req;
            hold_reg   <= (eff_hold == HOLD_FIRE) ? HOLD_RELOAD : eff_hold + 5'd1;
        end
    end
`else
    assign step_up = up_req;
    assign step_dn = dn_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg    <= MIN_N;
            carry_reg    <= 1'b0;
            borrow_reg   <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            carry_reg    <= 1'b0;
            borrow_reg   <= 1'b0;
            load_err_reg <= 1'b0;
            if (load) begin
                if (load_ok)
                    count_reg <= N'(load_val);
                else
                    load_err_reg <= 1'b1;
            end else if (count_reg > lim) begin
                count_reg <= lim;
            end else if (step_up) begin
                if (count_reg >= lim) begin
                    count_reg <= MIN_N;
                    carry_reg <= 1'b1;
                end else begin
                    count_reg <= count_reg + N'(1);
                end
            end else if (step_dn) begin
                if (count_reg <= MIN_N) begin
                    count_reg  <= lim;
                    borrow_reg <= 1'b1;
                end else begin
                    count_reg <= count_reg - N'(1);
                end
            end
        end
    end

    bin2bcd_dig #(.N(N), .DIGITS(DIGITS)) u_bin2bcd (
        .bin (count_reg),
        .bcd (bcd_comb)
    );

    always_ff @(posedge clk) begin
        if (reset)
            data_bcd_reg <= RST_BCD;
        else
            data_bcd_reg <= bcd_comb;
    end

    assign data_bcd  = data_bcd_reg;
    assign count_bin = count_reg;
    assign carry     = carry_reg;
    assign borrow    = borrow_reg;
    assign load_err  = load_err_reg;

endmodule
